// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1 I/D to L2 cache port arbiter.
package cache_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

endpackage

// File: rtl/cache_arbiter.sv
// Serialises I-cache and D-cache line transfers onto the single L2 port.
// Build option ARBITER_ROUND_ROBIN_EN: alternate conflict grants instead of fixed D priority.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_I,
    input  logic [ADDR_WIDTH-1:0] address_I,
    output logic [LINE_WIDTH-1:0] rdata_I,
    output logic                  resp_I,
    input  logic                  read_D,
    input  logic                  write_D,
    input  logic [ADDR_WIDTH-1:0] address_D,
    input  logic [LINE_WIDTH-1:0] wdata_D,
    output logic [LINE_WIDTH-1:0] rdata_D,
    output logic                  resp_D,
    output logic                  read_l2,
    output logic                  write_l2,
    output logic [ADDR_WIDTH-1:0] address_l2,
    output logic [LINE_WIDTH-1:0] wdata_l2,
    input  logic [LINE_WIDTH-1:0] rdata_l2,
    input  logic                  resp_l2,
    output logic                  id_conflict,
    output logic                  busy
);

    arb_state_t state, state_next;
    arb_src_t   grant;
    logic       req_i, req_d, conflict;

`ifdef ARBITER_ROUND_ROBIN_EN
    arb_src_t   last_grant;
`endif

    assign req_i = read_I;
    assign req_d = read_D | write_D;

    assign rdata_I = rdata_l2;
    assign rdata_D = rdata_l2;

    // Grant picker; only consulted while in IDLE.
    always_comb begin
        grant    = SRC_I;
        conflict = 1'b0;
        if (req_i && req_d) begin
            conflict = 1'b1;
`ifdef ARBITER_ROUND_ROBIN_EN
            grant = (last_grant == SRC_I) ? SRC_D : SRC_I;
`else
            grant = SRC_D;
`endif
        end else if (req_d) begin
            grant = SRC_D;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

`ifdef ARBITER_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= SRC_I;
        end else if (state == IDLE && (req_i || req_d)) begin
            last_grant <= grant;
        end
    end
`endif

    always_comb begin
        state_next  = state;
        read_l2     = 1'b0;
        write_l2    = 1'b0;
        address_l2  = '0;
        wdata_l2    = '0;
        resp_I      = 1'b0;
        resp_D      = 1'b0;
        id_conflict = 1'b0;
        busy        = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                // No decision is taken in a reset cycle, so no conflict event either.
                id_conflict = conflict && !reset;
                if (req_i || req_d) begin
                    state_next = (grant == SRC_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                read_l2    = 1'b1;
                address_l2 = address_I;
                resp_I     = resp_l2;
                if (resp_l2) state_next = IDLE;
            end
            SERVE_D: begin
                // A simultaneous read+write request is treated as a writeback.
                write_l2   = write_D;
                read_l2    = read_D && !write_D;
                address_l2 = address_D;
                wdata_l2   = wdata_D;
                resp_D     = resp_l2;
                if (resp_l2) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: vector table, corner-case sequences, randomized run vs reference model.
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
`ifdef ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          read_I, read_D, write_D, resp_l2;
    logic [AW-1:0] address_I, address_D;
    logic [LW-1:0] wdata_D, rdata_l2;
    logic [LW-1:0] rdata_I, rdata_D, wdata_l2;
    logic          resp_I, resp_D, read_l2, write_l2, id_conflict, busy;
    logic [AW-1:0] address_l2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .read_I(read_I), .address_I(address_I), .rdata_I(rdata_I), .resp_I(resp_I),
        .read_D(read_D), .write_D(write_D), .address_D(address_D), .wdata_D(wdata_D),
        .rdata_D(rdata_D), .resp_D(resp_D),
        .read_l2(read_l2), .write_l2(write_l2), .address_l2(address_l2), .wdata_l2(wdata_l2),
        .rdata_l2(rdata_l2), .resp_l2(resp_l2),
        .id_conflict(id_conflict), .busy(busy)
    );

    task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rst, input logic ri, input logic rd, input logic wd, input logic rl);
        reset = rst; read_I = ri; read_D = rd; write_D = wd; resp_l2 = rl;
        rdata_l2 = {8{$urandom}};
    endtask

    // Vector table: one row per clock cycle.
    typedef struct {
        logic          rst, ri, rd, wd, rl;
        logic [AW-1:0] ai, ad;
        logic          e_rl2, e_wl2, e_ri, e_rd, e_cf, e_bsy;
        logic [AW-1:0] e_addr;
        logic          e_wd;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic rst, input logic ri, input logic rd, input logic wd,
                                input logic rl, input logic [AW-1:0] ai, input logic [AW-1:0] ad,
                                input logic e_rl2, input logic e_wl2, input logic e_ri,
                                input logic e_rd, input logic e_cf, input logic e_bsy,
                                input logic [AW-1:0] e_addr, input logic e_wd);
        vec_t v;
        v.rst = rst; v.ri = ri; v.rd = rd; v.wd = wd; v.rl = rl; v.ai = ai; v.ad = ad;
        v.e_rl2 = e_rl2; v.e_wl2 = e_wl2; v.e_ri = e_ri; v.e_rd = e_rd; v.e_cf = e_cf;
        v.e_bsy = e_bsy; v.e_addr = e_addr; v.e_wd = e_wd;
        return v;
    endfunction

    // Reference model: which requester owns the L2 port (0 none, 1 I, 2 D) and who won last.
    int m_owner;
    int m_last;

    task automatic check_model();
        logic          e_rl2, e_wl2, e_ri, e_rd, e_cf, e_bsy;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_wdata;
        e_bsy   = (m_owner != 0);
        e_cf    = (m_owner == 0) && read_I && (read_D || write_D) && !reset;
        e_rl2   = (m_owner == 1) || (m_owner == 2 && read_D && !write_D);
        e_wl2   = (m_owner == 2) && write_D;
        e_addr  = (m_owner == 1) ? address_I : (m_owner == 2) ? address_D : '0;
        e_wdata = (m_owner == 2) ? wdata_D : '0;
        e_ri    = (m_owner == 1) && resp_l2;
        e_rd    = (m_owner == 2) && resp_l2;
        chk("rnd_read_l2", LW'(read_l2), LW'(e_rl2));
        chk("rnd_write_l2", LW'(write_l2), LW'(e_wl2));
        chk("rnd_address_l2", LW'(address_l2), LW'(e_addr));
        chk("rnd_wdata_l2", wdata_l2, e_wdata);
        chk("rnd_resp_I", LW'(resp_I), LW'(e_ri));
        chk("rnd_resp_D", LW'(resp_D), LW'(e_rd));
        chk("rnd_id_conflict", LW'(id_conflict), LW'(e_cf));
        chk("rnd_busy", LW'(busy), LW'(e_bsy));
        chk("rnd_rdata_I", rdata_I, rdata_l2);
        chk("rnd_rdata_D", rdata_D, rdata_l2);
    endtask

    task automatic model_step();
        bit wi, wd;
        wi = read_I;
        wd = read_D || write_D;
        if (reset) begin
            m_owner = 0;
            m_last  = 1;
        end else if (m_owner == 0) begin
            if (wi && wd) m_owner = RR ? ((m_last == 1) ? 2 : 1) : 2;
            else if (wd)  m_owner = 2;
            else if (wi)  m_owner = 1;
            if (m_owner != 0) m_last = m_owner;
        end else if (resp_l2) begin
            m_owner = 0;
        end
    endtask

    initial begin
        logic [LW-1:0] a5;
        bit i_act, d_act;
        a5 = {32{8'hA5}};

        // rst ri rd wd rl  ai     ad       | rl2 wl2 rI rD cf bsy addr    wd
        vecs[0]  = mk(1,0,0,0,0, 32'h40, 32'h100, 0,0,0,0,0,0, 32'h0,   0);
        vecs[1]  = mk(0,1,0,0,0, 32'h40, 32'h100, 0,0,0,0,0,0, 32'h0,   0);
        vecs[2]  = mk(0,1,0,0,0, 32'h40, 32'h100, 1,0,0,0,0,1, 32'h40,  0);
        vecs[3]  = mk(0,1,0,0,0, 32'h40, 32'h100, 1,0,0,0,0,1, 32'h40,  0);
        vecs[4]  = mk(0,1,0,0,0, 32'h40, 32'h100, 1,0,0,0,0,1, 32'h40,  0);
        vecs[5]  = mk(0,1,0,0,0, 32'h40, 32'h100, 1,0,0,0,0,1, 32'h40,  0);
        vecs[6]  = mk(0,1,0,0,1, 32'h40, 32'h100, 1,0,1,0,0,1, 32'h40,  0);
        vecs[7]  = mk(0,0,0,0,0, 32'h40, 32'h100, 0,0,0,0,0,0, 32'h0,   0);
        vecs[8]  = mk(0,0,0,1,0, 32'h40, 32'h100, 0,0,0,0,0,0, 32'h0,   0);
        vecs[9]  = mk(0,0,0,1,0, 32'h40, 32'h100, 0,1,0,0,0,1, 32'h100, 1);
        vecs[10] = mk(0,0,0,1,1, 32'h40, 32'h100, 0,1,0,1,0,1, 32'h100, 1);
        vecs[11] = mk(0,0,0,0,0, 32'h40, 32'h100, 0,0,0,0,0,0, 32'h0,   0);
        vecs[12] = mk(0,0,1,1,0, 32'h40, 32'h100, 0,0,0,0,0,0, 32'h0,   0);
        vecs[13] = mk(0,0,1,1,0, 32'h40, 32'h100, 0,1,0,0,0,1, 32'h100, 1);
        vecs[14] = mk(0,0,1,1,1, 32'h40, 32'h100, 0,1,0,1,0,1, 32'h100, 1);
        vecs[15] = mk(0,0,0,0,0, 32'h40, 32'h100, 0,0,0,0,0,0, 32'h0,   0);
        vecs[16] = mk(0,0,0,0,1, 32'h40, 32'h100, 0,0,0,0,0,0, 32'h0,   0);

        address_I = '0; address_D = '0; wdata_D = a5;
        set_in(1, 0, 0, 0, 0);
        next_cycle();

        for (int i = 0; i < 17; i++) begin
            set_in(vecs[i].rst, vecs[i].ri, vecs[i].rd, vecs[i].wd, vecs[i].rl);
            address_I = vecs[i].ai;
            address_D = vecs[i].ad;
            @(negedge clk);
            chk($sformatf("v%0d_read_l2", i), LW'(read_l2), LW'(vecs[i].e_rl2));
            chk($sformatf("v%0d_write_l2", i), LW'(write_l2), LW'(vecs[i].e_wl2));
            chk($sformatf("v%0d_resp_I", i), LW'(resp_I), LW'(vecs[i].e_ri));
            chk($sformatf("v%0d_resp_D", i), LW'(resp_D), LW'(vecs[i].e_rd));
            chk($sformatf("v%0d_id_conflict", i), LW'(id_conflict), LW'(vecs[i].e_cf));
            chk($sformatf("v%0d_busy", i), LW'(busy), LW'(vecs[i].e_bsy));
            chk($sformatf("v%0d_address_l2", i), LW'(address_l2), LW'(vecs[i].e_addr));
            chk($sformatf("v%0d_wdata_l2", i), wdata_l2, vecs[i].e_wd ? a5 : '0);
            chk($sformatf("v%0d_rdata_I", i), rdata_I, rdata_l2);
            chk($sformatf("v%0d_rdata_D", i), rdata_D, rdata_l2);
            next_cycle();
        end

        // Two back-to-back conflicts: the D request is re-raised in the bubble after its response.
        set_in(1, 0, 0, 0, 0);
        next_cycle();
        address_I = 32'h40; address_D = 32'h200;
        set_in(0, 1, 1, 0, 0);
        @(negedge clk);
        chk("cf1_id_conflict", LW'(id_conflict), LW'(1'b1));
        chk("cf1_busy", LW'(busy), LW'(1'b0));
        next_cycle();
        set_in(0, 1, 1, 0, 0);
        @(negedge clk);
        chk("cf1_grant_addr", LW'(address_l2), LW'(32'h200));
        chk("cf1_conflict_once", LW'(id_conflict), LW'(1'b0));
        next_cycle();
        set_in(0, 1, 1, 0, 1);
        @(negedge clk);
        chk("cf1_resp_D", LW'(resp_D), LW'(1'b1));
        chk("cf1_resp_I", LW'(resp_I), LW'(1'b0));
        next_cycle();
        set_in(0, 1, 1, 0, 0);
        @(negedge clk);
        chk("cf2_bubble_busy", LW'(busy), LW'(1'b0));
        chk("cf2_id_conflict", LW'(id_conflict), LW'(1'b1));
        next_cycle();
        set_in(0, 1, 1, 0, 0);
        @(negedge clk);
        chk("cf2_grant_addr", LW'(address_l2), RR ? LW'(32'h40) : LW'(32'h200));
        next_cycle();
        set_in(0, 1, 1, 0, 1);
        @(negedge clk);
        chk("cf2_resp_I", LW'(resp_I), LW'(RR));
        chk("cf2_resp_D", LW'(resp_D), LW'(!RR));
        next_cycle();
        set_in(0, !RR, RR, 0, 0);
        @(negedge clk);
        chk("cf3_bubble_busy", LW'(busy), LW'(1'b0));
        chk("cf3_no_conflict", LW'(id_conflict), LW'(1'b0));
        next_cycle();
        set_in(0, !RR, RR, 0, 1);
        @(negedge clk);
        chk("cf3_grant_addr", LW'(address_l2), RR ? LW'(32'h200) : LW'(32'h40));
        chk("cf3_resp_I", LW'(resp_I), LW'(!RR));
        next_cycle();

        // Reset in the third SERVE_I cycle, then a stray L2 response.
        address_I = 32'h80;
        set_in(0, 1, 0, 0, 0);
        next_cycle();
        set_in(0, 1, 0, 0, 0);
        @(negedge clk);
        chk("rst_serve_busy", LW'(busy), LW'(1'b1));
        next_cycle();
        set_in(0, 1, 0, 0, 0);
        next_cycle();
        set_in(1, 1, 0, 0, 0);
        next_cycle();
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_busy", LW'(busy), LW'(1'b0));
        chk("rst_read_l2", LW'(read_l2), LW'(1'b0));
        chk("rst_write_l2", LW'(write_l2), LW'(1'b0));
        chk("rst_address_l2", LW'(address_l2), LW'(0));
        next_cycle();
        set_in(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("rst_stray_resp_I", LW'(resp_I), LW'(1'b0));
        chk("rst_stray_busy", LW'(busy), LW'(1'b0));
        next_cycle();

        // Randomized run against the reference model, requesters obeying the hold-until-resp rule.
        set_in(1, 0, 0, 0, 0);
        m_owner = 0; m_last = 1;
        model_step();
        next_cycle();
        i_act = 0; d_act = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!i_act) begin
                address_I = $urandom;
                i_act = ($urandom % 3 == 0);
            end
            if (!d_act) begin
                logic [1:0] kind;
                kind = 2'($urandom_range(1, 3));
                address_D = $urandom;
                wdata_D = {8{$urandom}};
                d_act = ($urandom % 3 == 0);
                read_D = d_act && kind[0];
                write_D = d_act && kind[1];
            end
            read_I = i_act;
            resp_l2 = ($urandom % 4 == 0);
            rdata_l2 = {8{$urandom}};
            reset = ($urandom % 150 == 0);
            @(negedge clk);
            check_model();
            if (reset) begin
                i_act = 0; d_act = 0;
            end else if (resp_l2 && m_owner == 1) begin
                i_act = 0;
            end else if (resp_l2 && m_owner == 2) begin
                d_act = 0;
            end
            model_step();
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single L2 cache port between the L1 instruction cache (read-only) and the L1 data cache (read/write). The block sits between both L1 miss paths and the L2. It serialises their line transfers with a three-state FSM and forwards the L2 response to the requester that owns the grant. It also emits a one-cycle conflict pulse, which the performance counters use as the I/D conflict event.

## Interface
- ADDR_WIDTH, default 32: line address width.
- LINE_WIDTH, default 256: cache line data width.

- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- read_I  input  1  I-cache line read request; held until resp_I.
- address_I  input  ADDR_WIDTH  I-cache line address.
- rdata_I  output  LINE_WIDTH  line returned to I-cache.
- resp_I  output  1  I-cache transfer complete.
- read_D  input  1  D-cache line read request; held until resp_D.
- write_D  input  1  D-cache line writeback request; held until resp_D.
- address_D  input  ADDR_WIDTH  D-cache line address.
- wdata_D  input  LINE_WIDTH  D-cache writeback data.
- rdata_D  output  LINE_WIDTH  line returned to D-cache.
- resp_D  output  1  D-cache transfer complete.
- read_l2  output  1  L2 read strobe.
- write_l2  output  1  L2 write strobe.
- address_l2  output  ADDR_WIDTH  L2 address.
- wdata_l2  output  LINE_WIDTH  L2 write data.
- rdata_l2  input  LINE_WIDTH  L2 read data.
- resp_l2  input  1  L2 transfer complete.
- id_conflict  output  1  one-cycle pulse when both caches request in the same IDLE cycle.
- busy  output  1  FSM not in IDLE.

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- **IDLE**
  - Drives no L2 strobes; resp_I, resp_D, busy are 0.
  - Samples the requests. Only I pending → SERVE_I. Only D (read_D or write_D) pending → SERVE_D. None pending → stay in IDLE.
  - Both pending: priority rule decides the grant (see Configuration), and id_conflict=1 for that cycle.
- **SERVE_I**
  - read_l2=1, address_l2=address_I, write_l2=0.
  - rdata_I=rdata_l2 and resp_I=resp_l2, both combinational.
  - On resp_l2 → IDLE.
- **SERVE_D**
  - read_l2=read_D and write_l2=write_D; if both are high, write wins and read_l2 is forced to 0.
  - address_l2=address_D, wdata_l2=wdata_D.
  - rdata_D=rdata_l2 and resp_D=resp_l2.
  - On resp_l2 → IDLE.
- The non-granted requester sees resp=0 and keeps its request asserted; it is never dropped.
- resp_l2 arriving in IDLE is ignored.
- A requester deasserting mid-transfer is illegal; the FSM still waits for resp_l2.
- rdata_I and rdata_D pass rdata_l2 through unconditionally; only the resp signals are qualified.
- Unused outputs are driven to 0 (address_l2, wdata_l2 in IDLE).

## Timing
- Reset: state=IDLE, last_grant=I. All outputs 0: strobes, resp_*, id_conflict, busy, address_l2, wdata_l2.
- Reset mid-transfer: return to IDLE next edge. The pending L2 transaction is abandoned and the L2 must also be reset.
- Grant latency: a request seen in IDLE at edge t is driven to the L2 from cycle t+1.
- Release: resp_l2 in SERVE_x at cycle n raises resp_x combinationally in cycle n; the state is IDLE in cycle n+1.
  - Minimum one IDLE bubble between back-to-back transfers.
  - A request still high in cycle n+1 is treated as new.
- id_conflict is a Moore-free combinational function of IDLE and the requests, high exactly one cycle per conflict decision.

## Configuration
- ARBITER_ROUND_ROBIN_EN
  - Defined: on conflict, grant the requester not granted last. A 1-bit last_grant register is updated on every grant (reset=I, so the first conflict goes to D).
  - Undefined: fixed priority, D always wins a conflict and last_grant is not implemented.

## Structure
- Shared package holds `arb_state_t` (IDLE, SERVE_I, SERVE_D) and `arb_src_t` (SRC_I, SRC_D).
- Single module with no sub-module. The FSM is roughly 150–200 lines, and the grant picker stays an always_comb block inside it.

## Test plan
- I-only: read_I=1, address_I=0x0000_0040; L2 resp after 5 cycles.
  - Expect read_l2=1 with address 0x40 from cycle 1.
  - Expect resp_I on the resp_l2 cycle with rdata_I=rdata_l2.
  - Expect IDLE next cycle.
- D writeback: write_D=1, address_D=0x100, wdata_D=0xA5…A5.
  - Expect write_l2=1, wdata_l2 matching, read_l2=0, and resp_D on resp_l2.
- Conflict, fixed priority: read_I and read_D both high in IDLE.
  - Expect id_conflict=1 for one cycle and SERVE_D first.
  - After resp_D, one IDLE cycle, then SERVE_I.
- Conflict, round-robin (macro defined): two successive conflicts.
  - Expect grants D then I; each conflict raises id_conflict once.
- Reset mid-transfer: assert reset in cycle 3 of SERVE_I.
  - Expect IDLE, busy=0 and all strobes 0 next cycle.
  - A stray resp_l2 afterwards produces no resp_I.
- read_D and write_D both high: expect write_l2=1, read_l2=0.
